// File: rtl/reg_dump_monitor_pkg.sv
// reg_dump_monitor shared types and constants.
// State encoding, word tags and bus widths.
package reg_dump_monitor_pkg;

    localparam int DBG_AW = 5;
    localparam int WORD_W = 32;
    localparam int IDX_W  = 6;

    // Word tag used for the PC; register words carry their own number.
    localparam logic [IDX_W-1:0] IDX_PC = 6'd32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_SEND,
        S_DONE
    } state_e;

endpackage

// File: rtl/reg_dump_monitor_if.sv
// reg_dump_monitor output stream.
// Ready/valid word channel toward the formatter.
interface reg_dump_monitor_if;
    import reg_dump_monitor_pkg::*;

    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;
    logic [IDX_W-1:0]  out_idx;

    modport master (
        output out_valid,
        output out_data,
        output out_idx,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_idx,
        output out_ready
    );

endinterface

// File: rtl/reg_dump_monitor.sv
// reg_dump_monitor: walks the register-file debug port and
// streams PC + r0..r31 (or one register) over ready/valid.
module reg_dump_monitor
    import reg_dump_monitor_pkg::*;
#(
    parameter int NREGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode_single,
    input  logic [DBG_AW-1:0] sel_ra,
    input  logic [WORD_W-1:0] pc,
    output logic [DBG_AW-1:0] dbg_ra,
    input  logic [WORD_W-1:0] dbg_rd,
    reg_dump_monitor_if.master ob,
    output logic              busy,
    output logic              halt,
    output logic              done
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NREGS - 1);

    state_e            state_q, state_d;
    logic [DBG_AW-1:0] dbg_ra_q, dbg_ra_d;
    logic [WORD_W-1:0] out_data_q, out_data_d;
    logic [IDX_W-1:0]  out_idx_q, out_idx_d;
    logic              single_q, single_d;
    logic              accept;

    assign accept = (state_q == S_SEND) && ob.out_ready;

    // State and capture registers; reset abandons any dump at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            dbg_ra_q   <= '0;
            out_data_q <= '0;
            out_idx_q  <= '0;
            single_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            dbg_ra_q   <= dbg_ra_d;
            out_data_q <= out_data_d;
            out_idx_q  <= out_idx_d;
            single_q   <= single_d;
        end
    end

    // Next state: PC word first in full mode, then ADDR/SEND per register.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = mode_single ? S_ADDR : S_SEND;
            end
            S_ADDR: state_d = S_SEND;
            S_SEND: begin
                if (accept) begin
                    if (single_q || out_idx_q == IDX_LAST) state_d = S_DONE;
                    else                                   state_d = S_ADDR;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Capture path: latch request, read address and the word being offered.
    always_comb begin
        dbg_ra_d   = dbg_ra_q;
        out_data_d = out_data_q;
        out_idx_d  = out_idx_q;
        single_d   = single_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    single_d = mode_single;
                    if (mode_single) begin
                        dbg_ra_d = sel_ra;
                    end else begin
                        out_data_d = pc;
                        out_idx_d  = IDX_PC;
                    end
                end
            end
            S_ADDR: begin
                out_data_d = dbg_rd;
                out_idx_d  = {1'b0, dbg_ra_q};
            end
            S_SEND: begin
                if (accept && !single_q && out_idx_q != IDX_LAST) begin
                    if (out_idx_q == IDX_PC) dbg_ra_d = '0;
                    else dbg_ra_d = DBG_AW'(out_idx_q + 6'd1);
                end
            end
            default: begin
                dbg_ra_d = dbg_ra_q;
            end
        endcase
    end

    // Outputs decoded from state so reset clears them asynchronously.
    always_comb begin
        ob.out_valid = (state_q == S_SEND);
        busy         = (state_q == S_ADDR) || (state_q == S_SEND);
        halt         = busy;
        done         = (state_q == S_DONE);
    end

    assign ob.out_data = out_data_q;
    assign ob.out_idx  = out_idx_q;
    assign dbg_ra      = dbg_ra_q;

endmodule
